// File: rtl/des_pkg.sv
// Shared DES constants: permutation index tables (DES 1-based, MSB first), S-boxes,
// key rotation schedules, FSM state type and width constants.
package des_pkg;

    localparam int BLOCK_W  = 64;
    localparam int HALF_W   = 32;
    localparam int SUBKEY_W = 48;
    localparam int CD_W     = 28;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int IP_TBL [0:63] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_TBL [0:63] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_TBL [0:47] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_TBL [0:31] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_TBL [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TBL [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Address = {box[2:0], row[1:0], col[3:0]}
    localparam int SBOX [0:511] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

    // Decryption walks the key schedule backwards, so round 0 uses the unrotated C0/D0 (K16)
    localparam int ROT_DEC [0:15] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int ROT_ENC [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [CD_W-1:0] rot_left(input logic [CD_W-1:0] x, input int n);
        case (n)
            1:       rot_left = {x[CD_W-2:0], x[CD_W-1]};
            2:       rot_left = {x[CD_W-3:0], x[CD_W-1:CD_W-2]};
            default: rot_left = x;
        endcase
    endfunction

    function automatic logic [CD_W-1:0] rot_right(input logic [CD_W-1:0] x, input int n);
        case (n)
            1:       rot_right = {x[0], x[CD_W-1:1]};
            2:       rot_right = {x[1:0], x[CD_W-1:2]};
            default: rot_right = x;
        endcase
    endfunction

endpackage

// File: rtl/des_feistel_f.sv
// DES round function f(R,K): E-expansion, subkey XOR, eight S-boxes, P permutation.
module des_feistel_f
    import des_pkg::*;
(
    input  logic [HALF_W-1:0]   r_half,
    input  logic [SUBKEY_W-1:0] subkey,
    output logic [HALF_W-1:0]   f_out
);

    logic [SUBKEY_W-1:0] e_out;
    logic [SUBKEY_W-1:0] x_in;
    logic [HALF_W-1:0]   s_out;

    genvar gi;
    generate
        for (gi = 0; gi < SUBKEY_W; gi++) begin : g_exp
            assign e_out[SUBKEY_W-1-gi] = r_half[HALF_W-E_TBL[gi]];
        end
    endgenerate

    assign x_in = e_out ^ subkey;

    generate
        for (gi = 0; gi < 8; gi++) begin : g_sbox
            logic [5:0] six;
            logic [8:0] addr;
            assign six  = x_in[SUBKEY_W-1-6*gi -: 6];
            // Outer bits select the row, inner four the column
            assign addr = {3'(gi), six[5], six[0], six[4:1]};
            assign s_out[HALF_W-1-4*gi -: 4] = 4'(SBOX[addr]);
        end
        for (gi = 0; gi < HALF_W; gi++) begin : g_perm
            assign f_out[HALF_W-1-gi] = s_out[HALF_W-P_TBL[gi]];
        end
    endgenerate

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES block engine, one Feistel round per clock, valid/ready on both sides.
// DES_DEC_ENC_MODE_EN adds i_mode (1 = encrypt, 0 = decrypt), captured at acceptance.
module des_decrypt_iter
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [BLOCK_W-1:0] i_data,
    input  logic [BLOCK_W-1:0] i_key,
`ifdef DES_DEC_ENC_MODE_EN
    input  logic               i_mode,
`endif
    output logic               o_valid,
    input  logic               i_ready,
    output logic [BLOCK_W-1:0] o_data,
    output logic               o_busy
);

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic [HALF_W-1:0]   l_reg, l_next, r_reg, r_next;
    logic [CD_W-1:0]     c_reg, c_next, d_reg, d_next;
    logic [BLOCK_W-1:0]  data_reg, data_next;
    logic                valid_reg, valid_next;
`ifdef DES_DEC_ENC_MODE_EN
    logic                mode_reg, mode_next;
`endif

    logic [BLOCK_W-1:0]  ip_out, fp_in, fp_out;
    logic [2*CD_W-1:0]   pc1_out, cd_rot;
    logic [CD_W-1:0]     c_rot, d_rot;
    logic [SUBKEY_W-1:0] subkey;
    logic [HALF_W-1:0]   f_out;
    logic                unused_parity;

    assign unused_parity = ^{i_key[56], i_key[48], i_key[40], i_key[32],
                             i_key[24], i_key[16], i_key[8], i_key[0]};

`ifdef DES_DEC_ENC_MODE_EN
    assign c_rot = mode_reg ? rot_left(c_reg, ROT_ENC[cnt_reg]) : rot_right(c_reg, ROT_DEC[cnt_reg]);
    assign d_rot = mode_reg ? rot_left(d_reg, ROT_ENC[cnt_reg]) : rot_right(d_reg, ROT_DEC[cnt_reg]);
`else
    assign c_rot = rot_right(c_reg, ROT_DEC[cnt_reg]);
    assign d_rot = rot_right(d_reg, ROT_DEC[cnt_reg]);
`endif
    assign cd_rot = {c_rot, d_rot};

    // Pre-output block is {R16, L16}: the round's new R/L halves swapped
    assign fp_in = {l_reg ^ f_out, r_reg};

    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_W; gi++) begin : g_ipfp
            assign ip_out[BLOCK_W-1-gi] = i_data[BLOCK_W-IP_TBL[gi]];
            assign fp_out[BLOCK_W-1-gi] = fp_in[BLOCK_W-FP_TBL[gi]];
        end
        for (gi = 0; gi < 2*CD_W; gi++) begin : g_pc1
            assign pc1_out[2*CD_W-1-gi] = i_key[BLOCK_W-PC1_TBL[gi]];
        end
        for (gi = 0; gi < SUBKEY_W; gi++) begin : g_pc2
            assign subkey[SUBKEY_W-1-gi] = cd_rot[2*CD_W-PC2_TBL[gi]];
        end
    endgenerate

    des_feistel_f u_feistel (
        .r_half (r_reg),
        .subkey (subkey),
        .f_out  (f_out)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        l_next     = l_reg;
        r_next     = r_reg;
        c_next     = c_reg;
        d_next     = d_reg;
        data_next  = data_reg;
        valid_next = valid_reg;
`ifdef DES_DEC_ENC_MODE_EN
        mode_next  = mode_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (i_valid) begin
                    l_next     = ip_out[BLOCK_W-1:HALF_W];
                    r_next     = ip_out[HALF_W-1:0];
                    c_next     = pc1_out[2*CD_W-1:CD_W];
                    d_next     = pc1_out[CD_W-1:0];
                    cnt_next   = 4'd0;
`ifdef DES_DEC_ENC_MODE_EN
                    mode_next  = i_mode;
`endif
                    state_next = RUN;
                end
            end
            RUN: begin
                l_next   = r_reg;
                r_next   = l_reg ^ f_out;
                c_next   = c_rot;
                d_next   = d_rot;
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == 4'(NUM_ROUNDS-1)) begin
                    data_next  = fp_out;
                    valid_next = 1'b1;
                    cnt_next   = 4'd0;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            l_reg     <= '0;
            r_reg     <= '0;
            c_reg     <= '0;
            d_reg     <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
`ifdef DES_DEC_ENC_MODE_EN
            mode_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            l_reg     <= l_next;
            r_reg     <= r_next;
            c_reg     <= c_next;
            d_reg     <= d_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
`ifdef DES_DEC_ENC_MODE_EN
            mode_reg  <= mode_next;
`endif
        end
    end

    assign o_ready = (state_reg == IDLE);
    assign o_busy  = (state_reg == RUN);
    assign o_valid = valid_reg;
    assign o_data  = data_reg;

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Scoreboard bench for des_decrypt_iter: known-answer DES vectors, hold, reset abort, back-to-back.
module tb_des_decrypt_iter;

    logic        i_clk, i_rst, i_valid, i_ready;
    logic [63:0] i_data, i_key;
    logic        o_ready, o_valid, o_busy;
    logic [63:0] o_data;
`ifdef DES_DEC_ENC_MODE_EN
    logic        i_mode;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [63:0] exp_q[$];
    int          acc_q[$];
    bit          prev_valid = 0;
    bit          ready_chk  = 0;

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1, C1 = 64'h85E813540F0AB405, P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73, C2 = 64'h0000000000000000, P2 = 64'h8787878787878787;
    localparam logic [63:0] K3 = 64'h0101010101010101, C3 = 64'h8CA64DE9C1B123A7, P3 = 64'h0000000000000000;

    des_decrypt_iter #(.NUM_ROUNDS(16)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_key   (i_key),
`ifdef DES_DEC_ENC_MODE_EN
        .i_mode  (i_mode),
`endif
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_busy  (o_busy)
    );

    initial i_clk = 0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s %h", tag, got);
        end
    endtask

    // Output-side scoreboard: latency on each rising o_valid, data on each handshake
    always @(negedge i_clk) begin
        if (i_rst) begin
            prev_valid = 0;
            ready_chk  = 0;
        end else begin
            if (ready_chk) begin
                check("ready_after_hs", 64'(o_ready), 64'd1);
                ready_chk = 0;
            end
            if (o_valid && !prev_valid) begin
                if (acc_q.size() > 0) check("latency", 64'(cyc - acc_q.pop_front()), 64'd17);
                else check("latency_unexpected", 64'(o_valid), 64'd0);
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() > 0) check("plaintext", o_data, exp_q.pop_front());
                else check("data_unexpected", 64'(o_valid), 64'd0);
                ready_chk = 1;
            end
            prev_valid = o_valid;
        end
    end

    task automatic send(input logic [63:0] key, input logic [63:0] ct, input logic [63:0] exp, input bit mode);
        int n;
        i_key   = key;
        i_data  = ct;
        i_valid = 1;
`ifdef DES_DEC_ENC_MODE_EN
        i_mode  = mode;
`endif
        n = 0;
        @(negedge i_clk);
        while (!o_ready && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        check("accept_ready", 64'(o_ready), 64'd1);
        if (o_ready) begin
            exp_q.push_back(exp);
            acc_q.push_back(cyc);
        end
        @(posedge i_clk);
        #1;
        i_valid = 0;
        i_data  = {$urandom, $urandom};
        i_key   = {$urandom, $urandom};
`ifdef DES_DEC_ENC_MODE_EN
        i_mode  = ~mode;
`endif
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(posedge i_clk);
            n++;
        end
        #1;
        check("drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge i_clk);
        while (!o_valid && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check("valid_seen", 64'(o_valid), 64'd1);
    endtask

    initial begin
        i_rst = 1; i_valid = 0; i_ready = 0; i_data = 0; i_key = 0;
`ifdef DES_DEC_ENC_MODE_EN
        i_mode = 0;
`endif
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_busy",  64'(o_busy),  64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_data",  o_data,       64'd0);
        @(posedge i_clk); #1;
        i_rst   = 0;
        i_ready = 1;

        send(K1, C1, P1, 0); drain();
        send(K2, C2, P2, 0); drain();

        // Sink stalls: output must hold
        i_ready = 0;
        send(K3, C3, P3, 0);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            check("hold_data",  o_data,          P3);
            check("hold_valid", 64'(o_valid),    64'd1);
            check("hold_ready", 64'(o_ready),    64'd0);
        end
        @(posedge i_clk); #1;
        i_ready = 1;
        drain();

        send(K2, C2, P2, 0); drain();

        // Abort at round 8
        send(K1, C1, P1, 0);
        repeat (8) @(posedge i_clk);
        #1;
        i_rst = 1;
        @(negedge i_clk);
        check("pre_rst_busy", 64'(o_busy), 64'd1);
        @(posedge i_clk); #1;
        i_rst = 0;
        exp_q.delete();
        acc_q.delete();
        @(negedge i_clk);
        check("abort_valid", 64'(o_valid), 64'd0);
        check("abort_busy",  64'(o_busy),  64'd0);
        check("abort_ready", 64'(o_ready), 64'd1);
        check("abort_data",  o_data,       64'd0);
        @(posedge i_clk); #1;
        send(K3, C3, P3, 0); drain();

        // Back-to-back with the sink always ready
        send(K1, C1, P1, 0);
        send(K2, C2, P2, 0);
        send(K3, C3, P3, 0);
        send(K1, C1, P1, 0);
        drain();

`ifdef DES_DEC_ENC_MODE_EN
        send(K1, P1, C1, 1); drain();
        send(K1, C1, P1, 0); drain();
`endif

        repeat (3) @(posedge i_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
